// File: rtl/ysyx_041461_pipe_ctrl.sv
// Hazard and stall controller for the 5-stage ysyx_041461 pipeline: per-stage load/bubble control and next-PC select.
// Optional performance counters are enabled by defining YSYX_041461_PERF_CNT_EN.
module ysyx_041461_pipe_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ready,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        exe_valid,
  input  logic        exe_is_load,
  input  logic [4:0]  exe_rd,
  input  logic        exe_busy,
  input  logic        exe_redirect,
  input  logic        mem_valid,
  input  logic        mem_req,
  input  logic        mem_ack,
  input  logic        mem_trap,
  output logic        pc_en,
  output logic        ifreg_en,
  output logic        idreg_en,
  output logic        exereg_en,
  output logic        memreg_en,
  output logic        wbreg_en,
  output logic        idreg_bubble,
  output logic        exereg_bubble,
  output logic        memreg_bubble,
  output logic        wbreg_bubble,
  output logic [1:0]  pc_sel,
  output logic        mem_timeout
`ifdef YSYX_041461_PERF_CNT_EN
  ,
  output logic [63:0] stall_cycles,
  output logic [63:0] flush_cnt
`endif
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       kill_pend_q, kill_pend_d;
  logic [7:0] cnt_q, cnt_d;

  logic       pc_en_c, ifreg_en_c, idreg_en_c, exereg_en_c, memreg_en_c, wbreg_en_c;
  logic       idreg_bubble_c, exereg_bubble_c, memreg_bubble_c, wbreg_bubble_c;
  logic [1:0] pc_sel_c;
  logic       mem_timeout_c;
  logic       load_use;

  assign load_use = exe_valid && exe_is_load && (exe_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == exe_rd)) || (id_use_rs2 && (id_rs2 == exe_rd)));

  // Reset only masks the outputs here; the flops see it through their async reset alone.
  always_comb begin
    pc_en_c         = 1'b1;
    ifreg_en_c      = 1'b1;
    idreg_en_c      = 1'b1;
    exereg_en_c     = 1'b1;
    memreg_en_c     = 1'b1;
    wbreg_en_c      = 1'b1;
    idreg_bubble_c  = 1'b0;
    exereg_bubble_c = 1'b0;
    memreg_bubble_c = 1'b0;
    wbreg_bubble_c  = 1'b0;
    pc_sel_c        = 2'b00;
    mem_timeout_c   = 1'b0;
    state_d         = state_q;
    kill_pend_d     = kill_pend_q;
    cnt_d           = cnt_q;
    case (state_q)
      RUN: begin
        if (mem_valid && mem_trap) begin
          pc_sel_c        = 2'b10;
          idreg_bubble_c  = 1'b1;
          exereg_bubble_c = 1'b1;
          memreg_bubble_c = 1'b1;
          kill_pend_d     = !if_ready;
        end else if (mem_valid && mem_req && !mem_ack) begin
          pc_en_c        = 1'b0;
          ifreg_en_c     = 1'b0;
          idreg_en_c     = 1'b0;
          exereg_en_c    = 1'b0;
          memreg_en_c    = 1'b0;
          wbreg_bubble_c = 1'b1;
          state_d        = MEM_WAIT;
          cnt_d          = 8'd0;
        end else if (exe_busy) begin
          pc_en_c         = 1'b0;
          ifreg_en_c      = 1'b0;
          idreg_en_c      = 1'b0;
          exereg_en_c     = 1'b0;
          memreg_bubble_c = 1'b1;
        end else if (exe_redirect) begin
          pc_sel_c        = 2'b01;
          idreg_bubble_c  = 1'b1;
          exereg_bubble_c = 1'b1;
          kill_pend_d     = !if_ready;
        end else if (load_use) begin
          pc_en_c         = 1'b0;
          ifreg_en_c      = 1'b0;
          idreg_en_c      = 1'b0;
          exereg_bubble_c = 1'b1;
        end else if (!if_ready) begin
          pc_en_c        = 1'b0;
          ifreg_en_c     = 1'b0;
          idreg_bubble_c = 1'b1;
        end else if (kill_pend_q) begin
          // The fetch arriving now was issued from the pre-redirect PC, so drop it.
          pc_en_c        = 1'b0;
          idreg_bubble_c = 1'b1;
          kill_pend_d    = 1'b0;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          state_d = RUN;
        end else if (cnt_q == CNT_LAST) begin
          mem_timeout_c = 1'b1;
          state_d       = RUN;
        end else begin
          pc_en_c        = 1'b0;
          ifreg_en_c     = 1'b0;
          idreg_en_c     = 1'b0;
          exereg_en_c    = 1'b0;
          memreg_en_c    = 1'b0;
          wbreg_bubble_c = 1'b1;
          cnt_d          = cnt_q + 8'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign {pc_en, ifreg_en, idreg_en, exereg_en, memreg_en, wbreg_en,
          idreg_bubble, exereg_bubble, memreg_bubble, wbreg_bubble,
          pc_sel, mem_timeout} =
         rst ? 13'd0 :
         {pc_en_c, ifreg_en_c, idreg_en_c, exereg_en_c, memreg_en_c, wbreg_en_c,
          idreg_bubble_c, exereg_bubble_c, memreg_bubble_c, wbreg_bubble_c,
          pc_sel_c, mem_timeout_c};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      kill_pend_q <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      kill_pend_q <= kill_pend_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef YSYX_041461_PERF_CNT_EN
  logic [63:0] stall_cycles_q, stall_cycles_d;
  logic [63:0] flush_cnt_q, flush_cnt_d;

  // A non-zero next-PC select marks exactly the cycles where a redirect or trap is taken.
  always_comb begin
    stall_cycles_d = stall_cycles_q + 64'(!pc_en_c);
    flush_cnt_d    = flush_cnt_q + 64'(pc_sel_c != 2'b00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= 64'd0;
      flush_cnt_q    <= 64'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_cnt    = flush_cnt_q;
`endif

endmodule
